// File: rtl/mem_lsu_pkg.sv
// rtl/mem_lsu_pkg.sv - shared constants and FSM state type for the load/store unit
package mem_lsu_pkg;

  localparam int BYTE_SIZE                     = 8;
  localparam int DEFAULT_LSU_LATENCY           = 1;
  localparam int DEFAULT_DATA_MEMORY_ADDR_SIZE = 7;

  localparam logic [1:0] LSU_SIZE_BYTE = 2'b00;
  localparam logic [1:0] LSU_SIZE_HALF = 2'b01;
  localparam logic [1:0] LSU_SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    LSU_IDLE   = 2'd0,
    LSU_ACCESS = 2'd1,
    LSU_DONE   = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane steering for stores and extraction/extension for loads
module mem_lane_align
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W / BYTE_SIZE)
) (
  input  logic [OFF_W-1:0]             offset_i,
  input  logic [1:0]                   size_i,
  input  logic                         unsigned_i,
  input  logic [DATA_W-1:0]            st_data_i,
  input  logic [DATA_W-1:0]            raw_i,
  output logic [DATA_W/BYTE_SIZE-1:0]  be_o,
  output logic [DATA_W-1:0]            st_word_o,
  output logic [DATA_W-1:0]            ld_data_o
);

  localparam int NB = DATA_W / BYTE_SIZE;

  logic [OFF_W-1:0]  lane_base;
  logic [OFF_W+2:0]  lane_shift;
  logic [DATA_W-1:0] ld_shifted;

  // Lowest selected lane and enable mask; one selection feeds both directions
  always_comb begin
    lane_base = '0;
    be_o      = '0;
    case (size_i)
      LSU_SIZE_BYTE: lane_base = offset_i;
      LSU_SIZE_HALF: lane_base = offset_i & ~OFF_W'(1);
      default:       lane_base = '0;
    endcase
    for (int k = 0; k < NB; k++) begin
      case (size_i)
        LSU_SIZE_BYTE: be_o[k] = (OFF_W'(k) == offset_i);
        LSU_SIZE_HALF: be_o[k] = ((OFF_W'(k) >> 1) == (offset_i >> 1));
        default:       be_o[k] = 1'b1;
      endcase
    end
  end

  assign lane_shift = {lane_base, 3'b000};
  assign st_word_o  = st_data_i << lane_shift;
  assign ld_shifted = raw_i >> lane_shift;

  // Right-align the selected lanes, then zero- or sign-extend sub-word loads
  always_comb begin
    ld_data_o = ld_shifted;
    case (size_i)
      LSU_SIZE_BYTE: ld_data_o = {{(DATA_W-8){~unsigned_i & ld_shifted[7]}}, ld_shifted[7:0]};
      LSU_SIZE_HALF: ld_data_o = {{(DATA_W-16){~unsigned_i & ld_shifted[15]}}, ld_shifted[15:0]};
      default:       ld_data_o = ld_shifted;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - multi-cycle byte-addressed data memory with load/store handshake
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int IO_BUS_SIZE    = 32,
  parameter int MEM_ADDR_SIZE  = DEFAULT_DATA_MEMORY_ADDR_SIZE,
  parameter int ACCESS_LATENCY = DEFAULT_LSU_LATENCY
) (
  input  logic                                 i_clk,
  input  logic                                 i_reset,
  input  logic                                 i_req,
  input  logic                                 i_wr_rd,
  input  logic [1:0]                           i_size,
  input  logic                                 i_unsigned,
  input  logic [IO_BUS_SIZE-1:0]               i_alu_res,
  input  logic [IO_BUS_SIZE-1:0]               i_bus_b,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_misaligned,
  output logic [IO_BUS_SIZE-1:0]               o_mem_rd,
  output logic [IO_BUS_SIZE-1:0]               o_alu_result,
  output logic [(2**MEM_ADDR_SIZE)*BYTE_SIZE-1:0] o_bus_debug
);

  localparam int NB       = IO_BUS_SIZE / BYTE_SIZE;
  localparam int OFF_W    = $clog2(NB);
  localparam int MEM_BITS = (2**MEM_ADDR_SIZE) * BYTE_SIZE;

  lsu_state_e               state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  logic                     wr_q, uns_q, mis_q;
  logic [1:0]               size_q;
  logic [IO_BUS_SIZE-1:0]   addr_q, data_q, rd_q;
  logic [MEM_BITS-1:0]      mem_q;

  logic                     accept, commit, req_mis;
  logic [OFF_W-1:0]         req_off;
  logic [MEM_ADDR_SIZE-1:0] word_base;
  logic [MEM_ADDR_SIZE+2:0] bit_idx;
  logic [IO_BUS_SIZE-1:0]   raw_word, st_word, ld_data, bit_mask, new_word;
  logic [NB-1:0]            be;

  assign req_off = i_alu_res[OFF_W-1:0];

  // Alignment of the incoming request: bytes always, halves on even, words on lane 0
  always_comb begin
    req_mis = 1'b0;
    case (i_size)
      LSU_SIZE_BYTE: req_mis = 1'b0;
      LSU_SIZE_HALF: req_mis = req_off[0];
      default:       req_mis = (req_off != '0);
    endcase
  end

  // Next-state logic: accept only in IDLE, count down in ACCESS, one cycle in DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        if (i_req) begin
          accept = 1'b1;
          if (req_mis) begin
            state_d = LSU_DONE;
          end else begin
            state_d = LSU_ACCESS;
            cnt_d   = 4'(ACCESS_LATENCY - 1);
          end
        end
      end
      LSU_ACCESS: begin
        if (cnt_q == 4'd0) begin
          commit  = 1'b1;
          state_d = LSU_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      LSU_DONE: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  // FSM state and latency counter
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= LSU_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request capture on accept and load-result register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wr_q   <= 1'b0;
      uns_q  <= 1'b0;
      mis_q  <= 1'b0;
      size_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      rd_q   <= '0;
    end else begin
      if (accept) begin
        wr_q   <= i_wr_rd;
        uns_q  <= i_unsigned;
        mis_q  <= req_mis;
        size_q <= i_size;
        addr_q <= i_alu_res;
        data_q <= i_bus_b;
      end
      if (accept && req_mis) begin
        rd_q <= '0;
      end else if (commit && !wr_q) begin
        rd_q <= ld_data;
      end
    end
  end

  assign word_base = {addr_q[MEM_ADDR_SIZE-1:OFF_W], {OFF_W{1'b0}}};
  assign bit_idx   = {word_base, 3'b000};
  assign raw_word  = mem_q[bit_idx +: IO_BUS_SIZE];

  mem_lane_align #(
    .DATA_W (IO_BUS_SIZE),
    .OFF_W  (OFF_W)
  ) u_lane_align (
    .offset_i   (addr_q[OFF_W-1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .st_data_i  (data_q),
    .raw_i      (raw_word),
    .be_o       (be),
    .st_word_o  (st_word),
    .ld_data_o  (ld_data)
  );

  // Merge enabled store lanes into the addressed word, leaving other bytes intact
  always_comb begin
    bit_mask = '0;
    for (int k = 0; k < NB; k++) begin
      bit_mask[k*BYTE_SIZE +: BYTE_SIZE] = {BYTE_SIZE{be[k]}};
    end
    new_word = (raw_word & ~bit_mask) | (st_word & bit_mask);
  end

  // Memory array; a store commits only on the final ACCESS cycle
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      mem_q <= '0;
    end else if (commit && wr_q) begin
      mem_q[bit_idx +: IO_BUS_SIZE] <= new_word;
    end
  end

  assign o_busy       = (state_q != LSU_IDLE);
  assign o_done       = (state_q == LSU_DONE);
  assign o_misaligned = o_done & mis_q;
  assign o_mem_rd     = rd_q;
  assign o_alu_result = addr_q;
  assign o_bus_debug  = mem_q;

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - randomized self-checking bench for mem_lsu at latencies 1 and 4
module tb_mem_lsu;

  logic        clk;
  logic        rst_n;
  logic        req, wr_rd, uns;
  logic [1:0]  size;
  logic [31:0] alu_res, bus_b;
  int          sel;

  logic         busy1, done1, mis1, busy4, done4, mis4;
  logic [31:0]  rd1, res1, rd4, res4;
  logic [1023:0] dbg1, dbg4;

  logic         busy, done, mis;
  logic [31:0]  rd, res;
  logic [1023:0] dbg;

  logic [7:0] mem_m [2][128];
  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_lsu #(.IO_BUS_SIZE(32), .MEM_ADDR_SIZE(7), .ACCESS_LATENCY(1)) dut1 (
    .i_clk(clk), .i_reset(rst_n), .i_req(req & (sel == 0)), .i_wr_rd(wr_rd),
    .i_size(size), .i_unsigned(uns), .i_alu_res(alu_res), .i_bus_b(bus_b),
    .o_busy(busy1), .o_done(done1), .o_misaligned(mis1), .o_mem_rd(rd1),
    .o_alu_result(res1), .o_bus_debug(dbg1));

  mem_lsu #(.IO_BUS_SIZE(32), .MEM_ADDR_SIZE(7), .ACCESS_LATENCY(4)) dut4 (
    .i_clk(clk), .i_reset(rst_n), .i_req(req & (sel == 1)), .i_wr_rd(wr_rd),
    .i_size(size), .i_unsigned(uns), .i_alu_res(alu_res), .i_bus_b(bus_b),
    .o_busy(busy4), .o_done(done4), .o_misaligned(mis4), .o_mem_rd(rd4),
    .o_alu_result(res4), .o_bus_debug(dbg4));

  assign busy = (sel == 1) ? busy4 : busy1;
  assign done = (sel == 1) ? done4 : done1;
  assign mis  = (sel == 1) ? mis4  : mis1;
  assign rd   = (sel == 1) ? rd4   : rd1;
  assign res  = (sel == 1) ? res4  : res1;
  assign dbg  = (sel == 1) ? dbg4  : dbg1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h sel=%0d t=%0t", tag, got, exp, sel, $time);
    end
  endtask

  task automatic clear_model();
    for (int s = 0; s < 2; s++)
      for (int b = 0; b < 128; b++) mem_m[s][b] = 8'h00;
  endtask

  task automatic chk_image(input string tag);
    logic [63:0] chunk;
    for (int c = 0; c < 16; c++) begin
      for (int j = 0; j < 8; j++) chunk[j*8 +: 8] = mem_m[sel][c*8 + j];
      chk(tag, dbg[c*64 +: 64], chunk);
    end
  endtask

  // One request: model computes the outcome from address/size rules alone
  task automatic do_op(input int s, input bit w, input logic [1:0] sz, input bit u,
                       input logic [31:0] addr, input logic [31:0] data, input bit hold);
    int n, nb, exp_lat;
    bit exp_mis;
    logic [6:0]  a;
    logic [31:0] v;
    sel = s;
    wr_rd = w; size = sz; uns = u; alu_res = addr; bus_b = data; req = 1'b1;
    a  = addr[6:0];
    nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    exp_mis = (nb == 2 && a[0]) || (nb == 4 && a[1:0] != 2'b00);
    v = 32'h0;
    if (!exp_mis) begin
      if (w) begin
        for (int k = 0; k < nb; k++) mem_m[s][a + k] = data[k*8 +: 8];
      end else begin
        for (int k = 0; k < nb; k++) v[k*8 +: 8] = mem_m[s][a + k];
        if (nb == 1 && !u) v = {{24{v[7]}}, v[7:0]};
        if (nb == 2 && !u) v = {{16{v[15]}}, v[15:0]};
      end
    end
    exp_lat = exp_mis ? 1 : ((s == 1) ? 5 : 2);
    @(posedge clk); #1;
    n = 1;
    if (!hold) req = 1'b0;
    wr_rd = 1'($urandom); size = 2'($urandom); uns = 1'($urandom);
    alu_res = $urandom; bus_b = $urandom;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    req = 1'b0;
    chk("latency", 64'(n), 64'(exp_lat));
    chk("misaligned", 64'(mis), 64'(exp_mis));
    chk("alu_result", 64'(res), 64'(addr));
    if (exp_mis || !w) chk("mem_rd", 64'(rd), 64'(v));
    @(posedge clk); #1;
    chk("done_pulse", 64'(done), 64'h0);
    chk("idle", 64'(busy), 64'h0);
    chk_image("image");
  endtask

  initial begin
    sel = 0; req = 0; wr_rd = 0; size = 0; uns = 0; alu_res = 0; bus_b = 0;
    rst_n = 1'b0;
    clear_model();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++) begin
      sel = s; #0;
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_done", 64'(done), 64'h0);
      chk("rst_mis", 64'(mis), 64'h0);
      chk("rst_rd", 64'(rd), 64'h0);
      chk("rst_res", 64'(res), 64'h0);
      chk_image("rst_image");
    end

    // Reset asserted mid-ACCESS of a store aborts it
    sel = 1; wr_rd = 1; size = 2'b10; alu_res = 32'h04; bus_b = 32'hCAFEF00D; req = 1;
    @(posedge clk); #1 req = 0;
    @(posedge clk); #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'h0);
    chk("abort_mem", 64'(dbg[63:32]), 64'h0);
    @(posedge clk); #1;

    do_op(0, 1, 2'b10, 0, 32'h08, 32'hDEADBEEF, 0);
    chk("plan_dbg8", 64'(dbg1[95:64]), 64'hDEADBEEF);
    do_op(0, 0, 2'b10, 0, 32'h08, 32'h0, 0);
    chk("plan_ldw", 64'(rd1), 64'hDEADBEEF);
    do_op(0, 1, 2'b00, 0, 32'h0A, 32'h80, 0);
    do_op(0, 0, 2'b00, 0, 32'h0A, 32'h0, 0);
    chk("plan_lbs", 64'(rd1), 64'hFFFFFF80);
    do_op(0, 0, 2'b00, 1, 32'h0A, 32'h0, 0);
    chk("plan_lbu", 64'(rd1), 64'h00000080);
    do_op(0, 0, 2'b10, 0, 32'h08, 32'h0, 0);
    chk("plan_merge", 64'(rd1), 64'hDE80BEEF);
    do_op(0, 1, 2'b01, 0, 32'h0E, 32'h8001, 0);
    do_op(0, 0, 2'b01, 0, 32'h0E, 32'h0, 0);
    chk("plan_lhs", 64'(rd1), 64'hFFFF8001);
    do_op(0, 0, 2'b01, 1, 32'h0E, 32'h0, 0);
    chk("plan_lhu", 64'(rd1), 64'h00008001);
    do_op(0, 0, 2'b00, 0, 32'h0F, 32'h0, 0);
    chk("plan_lb_hi", 64'(rd1), 64'hFFFFFF80);
    do_op(0, 0, 2'b10, 0, 32'h09, 32'h0, 0);
    do_op(0, 1, 2'b01, 0, 32'h03, 32'h1234, 0);
    do_op(1, 1, 2'b00, 0, 32'h7F, 32'h5A, 1);
    do_op(1, 0, 2'b00, 1, 32'h7F, 32'h0, 1);
    chk("plan_top", 64'(rd4), 64'h5A);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] ra;
      ra = $urandom;
      if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
      do_op(int'($urandom_range(0, 1)), 1'($urandom), 2'($urandom), 1'($urandom),
            ra, $urandom, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Parametrised successor to the MEM-stage data path.
- Byte-addressed, little-endian data memory with per-byte write enables for byte, halfword and word stores.
- Sign/zero-extended sub-word loads, selected by address offset.
- Configurable multi-cycle access latency with a request/busy/done handshake, plus misalignment detection.
- Sits between EX/MEM and MEM/WB; the hazard unit uses o_busy to stall the pipeline.

Parameters:
- IO_BUS_SIZE, 32, data word width in bits (multiple of 16).
- MEM_ADDR_SIZE, 7, byte-address bits; memory holds 2**MEM_ADDR_SIZE bytes.
- ACCESS_LATENCY, 1, cycles spent in ACCESS, range 1..15.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_req  in  1  access request; sampled only in IDLE.
- i_wr_rd  in  1  1 = store, 0 = load.
- i_size  in  2  00 byte, 01 halfword, 10 word; 11 is treated as word.
- i_unsigned  in  1  load extension: 1 = zero-extend, 0 = sign-extend.
- i_alu_res  in  IO_BUS_SIZE  byte address; the low MEM_ADDR_SIZE bits are used.
- i_bus_b  in  IO_BUS_SIZE  store data, right-aligned.
- o_busy  out  1  high while state is not IDLE.
- o_done  out  1  one-cycle pulse marking completion.
- o_misaligned  out  1  valid with o_done; access was not performed.
- o_mem_rd  out  IO_BUS_SIZE  extended load data; held until the next accept.
- o_alu_result  out  IO_BUS_SIZE  captured i_alu_res of the current or last request.
- o_bus_debug  out  2**MEM_ADDR_SIZE*8  flat memory image; byte k sits at bits [8k+7:8k].

Behaviour:
- Reset (i_reset low, asynchronous):
  - state = IDLE, latency counter = 0.
  - All outputs 0; all memory bytes cleared.
  - Reset mid-operation aborts the request; a pending store is never committed.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If i_req = 1 at a rising edge, capture i_wr_rd, i_size, i_unsigned, i_alu_res and i_bus_b into request registers.
  - o_alu_result takes the captured address.
  - If aligned, go to ACCESS with counter = ACCESS_LATENCY-1; otherwise go to DONE with the misaligned flag set.
- Alignment rules:
  - Halfword requires addr[0] = 0.
  - Word requires addr[1:0] = 0.
  - Byte is always aligned.
- ACCESS:
  - Counter decrements each cycle.
  - On the cycle the counter is 0:
    - Store: write enabled byte lanes at the word base address.
    - Load: register the extracted, extended data into o_mem_rd.
  - Then go to DONE.
- DONE:
  - o_done = 1 and o_misaligned = captured flag for exactly one cycle.
  - Return to IDLE.
  - A new request can be accepted on the edge that leaves DONE+1 (i.e. the cycle state is IDLE).
- Latency: request-accept edge to o_done high is ACCESS_LATENCY+1 cycles for aligned accesses, and 1 cycle for misaligned ones.
- i_req while o_busy = 1 is ignored; there is no queueing.
- Misaligned access: no memory write, o_mem_rd forced to 0, o_misaligned = 1.
- Store lanes:
  - Byte: bus_b[7:0] goes to lane addr[1:0].
  - Halfword: bus_b[15:0] goes to lanes addr[1]*2 and addr[1]*2+1.
  - Word: all lanes.
  - Unselected bytes are unchanged.
- Load extraction uses the same lane selection, then zero- or sign-extends to IO_BUS_SIZE. Word loads ignore i_unsigned.
- Addresses at the top of memory never wrap: alignment guarantees every lane is in range.
- o_bus_debug is combinational from the array and reflects a store the cycle after commit.

Decomposition:
- Shared header mem_lsu.vh holds:
  - Size codes: LSU_SIZE_BYTE, LSU_SIZE_HALF, LSU_SIZE_WORD.
  - FSM state encodings: LSU_IDLE, LSU_ACCESS, LSU_DONE.
  - BYTE_SIZE.
  - Defaults DEFAULT_LSU_LATENCY and DEFAULT_DATA_MEMORY_ADDR_SIZE.
- One combinational sub-module, mem_lane_align:
  - Store side: address offset, size and data in, byte-enable mask and lane-positioned store word out.
  - Load side: raw word, offset, size and unsigned flag in, extended load data out.
  - Its lane logic is shared by the store and load paths.

Test Plan:
- Reset then idle → all outputs 0, o_debug all 0; assert/deassert reset mid-ACCESS of a store to 0x04 → byte 0x04..0x07 remain 0, state IDLE.
- Store word 0xDEADBEEF @0x08 (LATENCY=1), then load word @0x08 → o_done 2 cycles after each accept, o_mem_rd = 0xDEADBEEF, debug bytes 8..11 = EF,BE,AD,DE.
- Store byte 0x80 @0x0A, then load byte signed @0x0A → 0xFFFFFF80; unsigned → 0x00000080; word @0x08 → 0xDE80BEEF.
- Store halfword 0x8001 @0x0E, then load half signed @0x0E → 0xFFFF8001; unsigned → 0x00008001; byte @0x0F signed → 0xFFFFFF80.
- Misaligned: load word @0x09, store half @0x03 (data 0x1234) → o_done 1 cycle after accept with o_misaligned = 1, o_mem_rd = 0, memory unchanged.
- ACCESS_LATENCY=4: i_req held high during busy → o_done exactly 5 cycles after accept, extra requests ignored; back-to-back requests accepted only in IDLE; last byte address 0x7F store/load byte 0x5A round-trips.
